wb_wrport_arb: RTL and testbench
================================

# wb_wrport_arb

Arbiter for the single integer register-file write port. It shares the port between the in-order pipeline writeback and a long-latency result source (load return / mul-div), and buffers long-latency results in a small FIFO. Pipeline writeback has priority. A starvation counter freezes the pipeline so buffered results always drain. The block sits between the writeback stage and the register file, and feeds a busy-lookup to decode.

## Interface
- DEPTH, 2, long-latency buffer entries (2..4)
- STARVE_MAX, 4, consecutive lost-arbitration cycles of the FIFO head before a stall is requested (1..15)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb_wr_reg  in  1  pipeline writeback request
- wb_wr_regindex  in  5  pipeline destination register
- wb_wr_wdata  in  32  pipeline write data
- ll_valid  in  1  long-latency result valid
- ll_regindex  in  5  long-latency destination register
- ll_wdata  in  32  long-latency data
- ll_ready  out  1  FIFO can accept; equals count < DEPTH
- wb2regfile_wr_reg  out  1  registered port write enable
- wb2regfile_wr_regindex  out  5  registered port index
- wb2regfile_wr_wdata  out  32  registered port data
- wb_stall_req  out  1  request to freeze the pipeline (registered)
- dec_rs1_index, dec_rs2_index  in  5 each  decode lookup indices
- dec_rs1_busy, dec_rs2_busy  out  1 each  combinational: index is nonzero and matches a valid FIFO entry

## Operation
- The FIFO is a circular buffer with rd_ptr, wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH) and a per-entry valid bit.
- Push: ll_valid && ll_ready && ll_regindex != 0. A write to x0 is accepted and discarded and does not occupy an entry.
- Effective pipeline request is wb_wr_reg && wb_wr_regindex != 0.
- Grant priority:
  - Effective pipeline request: port gets pipeline data.
  - Else, head valid: port gets head entry, which is popped.
  - Else, head invalid (squashed): pop without a write.
  - Else: port idle.
- WAW squash: when the pipeline write is granted and wb_wr_regindex matches a valid FIFO entry, that entry's valid bit clears the same cycle. An entry pushed in that cycle is not squashed.
- Push and pop in the same cycle are allowed, including at count == DEPTH. ll_ready is still 0 at full, so no push occurs at full.
- Starvation counter starve_cnt (4 bits):
  - Increments while the head is valid and the pipeline wins.
  - Clears on a head pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- wb_stall_req sets when starve_cnt reaches STARVE_MAX. It clears the cycle after the starved entry pops.
- While wb_stall_req = 1, the pipeline guarantees wb_wr_reg = 0.
- Reset mid-operation: all FIFO contents are dropped. Any long-latency result in flight before reset is not written.

## Timing
- Reset values:
  - wb2regfile_wr_reg = 0, wb2regfile_wr_regindex = 0, wb2regfile_wr_wdata = 0
  - wb_stall_req = 0, count = 0, pointers = 0, all valid bits = 0, starve_cnt = 0
  - ll_ready = 1 in the first cycle after reset
- Pipeline write latency: 1 cycle from wb_wr_reg to wb2regfile_wr_reg.
- Long-latency write latency: push in cycle N appears on the port no earlier than N+2 (enqueue, then arbitrate/register). There is no bypass.
- dec_rsX_busy reflects FIFO state after the previous edge. An entry is busy from the cycle after push until the cycle it pops (inclusive). Decode must also check the output register stage itself.
- ll_ready is combinational from count only. It does not depend on same-cycle pop.
- wb_stall_req asserts 1 cycle after starve_cnt reaches STARVE_MAX.

## Test plan
- Reset, then idle: all outputs 0, ll_ready = 1. wb_wr_reg = 1, index 5, data 0xDEADBEEF → port write to x5 with 0xDEADBEEF exactly 1 cycle later.
- Push ll x7 = 0x11 in cycle 0 with pipeline idle → dec_rs1_busy for x7 in cycle 1; port write x7 = 0x11 in cycle 2; busy = 0 in cycle 3.
- DEPTH = 2: push x3 and x4 while pipeline writes every cycle → ll_ready = 0 at count 2. Pipeline stops → x3 then x4 written in order, ll_ready = 1 after the first pop.
- Starvation, STARVE_MAX = 4: pipeline writes continuously with x9 buffered → wb_stall_req = 1 after 4 lost cycles. x9 written next, stall clears the following cycle.
- WAW squash: buffer x6 = 0xAA, pipeline writes x6 = 0xBB → port writes 0xBB only. Head is popped silently, count returns to 0.
- ll write to x0 → no push, count stays 0, no port write. Reset asserted with count = 2 → count 0 and no stale writes afterwards.

Source files
------------

// File: rtl/wb_wrport_arb.sv
// Register-file write-port arbiter.
// The in-order pipeline writeback always wins the single write port.
// Long-latency results (load return, mul/div) wait in a small circular FIFO
// until the port is free. A starvation counter raises a pipeline stall so
// buffered results are guaranteed to drain. Decode can ask whether a source
// register still has a result pending in the FIFO.
module wb_wrport_arb #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_wr_reg,
  input  logic [4:0]  wb_wr_regindex,
  input  logic [31:0] wb_wr_wdata,
  input  logic        ll_valid,
  input  logic [4:0]  ll_regindex,
  input  logic [31:0] ll_wdata,
  output logic        ll_ready,
  output logic        wb2regfile_wr_reg,
  output logic [4:0]  wb2regfile_wr_regindex,
  output logic [31:0] wb2regfile_wr_wdata,
  output logic        wb_stall_req,
  input  logic [4:0]  dec_rs1_index,
  input  logic [4:0]  dec_rs2_index,
  output logic        dec_rs1_busy,
  output logic        dec_rs2_busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // FIFO storage; payload is never reset, only the valid bits are.
  logic [4:0]       idx_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       starve_q, starve_d;
  logic             stall_q, stall_d;

  // Output port stage.
  logic        port_wr_q, port_wr_d;
  logic [4:0]  port_idx_q, port_idx_d;
  logic [31:0] port_data_q, port_data_d;

  logic wb_eff, push, pop, fifo_ne, head_vld;

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign ll_ready = (count_q < CNT_W'(DEPTH));
  assign wb_eff   = wb_wr_reg && (wb_wr_regindex != 5'd0);
  assign push     = ll_valid && ll_ready && (ll_regindex != 5'd0);
  assign fifo_ne  = (count_q != '0);
  assign head_vld = fifo_ne && vld_q[rd_ptr_q];
  // The head leaves whenever the pipeline does not claim the port,
  // whether it still carries a write or was squashed by a newer write.
  assign pop      = !wb_eff && fifo_ne;

  // Arbitration, WAW squash, FIFO bookkeeping and starvation tracking.
  always_comb begin
    vld_d       = vld_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    starve_d    = starve_q;
    port_wr_d   = 1'b0;
    port_idx_d  = port_idx_q;
    port_data_d = port_data_q;

    if (wb_eff) begin
      port_wr_d   = 1'b1;
      port_idx_d  = wb_wr_regindex;
      port_data_d = wb_wr_wdata;
      // An older buffered write to the same register is now dead.
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && (idx_q[i] == wb_wr_regindex)) vld_d[i] = 1'b0;
      end
    end else if (head_vld) begin
      port_wr_d   = 1'b1;
      port_idx_d  = idx_q[rd_ptr_q];
      port_data_d = data_q[rd_ptr_q];
    end

    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end
    // Applied after the squash so a freshly pushed entry stays valid.
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (!fifo_ne || pop)
      starve_d = 4'd0;
    else if (head_vld && wb_eff && (starve_q != 4'(STARVE_MAX)))
      starve_d = starve_q + 4'd1;

    // Stall is held off once the starved head has actually left.
    stall_d = (starve_q == 4'(STARVE_MAX)) && !pop;
  end

  // Control state and output port registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= 4'd0;
      stall_q     <= 1'b0;
      port_wr_q   <= 1'b0;
      port_idx_q  <= 5'd0;
      port_data_q <= 32'd0;
    end else begin
      vld_q       <= vld_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      stall_q     <= stall_d;
      port_wr_q   <= port_wr_d;
      port_idx_q  <= port_idx_d;
      port_data_q <= port_data_d;
    end
  end

  // FIFO payload capture on push.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_q[wr_ptr_q]  <= ll_regindex;
      data_q[wr_ptr_q] <= ll_wdata;
    end
  end

  // Decode busy lookup against the FIFO state after the previous edge.
  always_comb begin
    dec_rs1_busy = 1'b0;
    dec_rs2_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (dec_rs1_index != 5'd0) && (idx_q[i] == dec_rs1_index))
        dec_rs1_busy = 1'b1;
      if (vld_q[i] && (dec_rs2_index != 5'd0) && (idx_q[i] == dec_rs2_index))
        dec_rs2_busy = 1'b1;
    end
  end

  assign wb2regfile_wr_reg      = port_wr_q;
  assign wb2regfile_wr_regindex = port_idx_q;
  assign wb2regfile_wr_wdata    = port_data_q;
  assign wb_stall_req           = stall_q;

endmodule

// File: tb/tb_wb_wrport_arb.sv
// Bench for wb_wrport_arb: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_wb_wrport_arb;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_wr_reg;
  logic [4:0]  wb_wr_regindex;
  logic [31:0] wb_wr_wdata;
  logic        ll_valid;
  logic [4:0]  ll_regindex;
  logic [31:0] ll_wdata;
  logic        ll_ready;
  logic        wb2regfile_wr_reg;
  logic [4:0]  wb2regfile_wr_regindex;
  logic [31:0] wb2regfile_wr_wdata;
  logic        wb_stall_req;
  logic [4:0]  dec_rs1_index, dec_rs2_index;
  logic        dec_rs1_busy, dec_rs2_busy;

  wb_wrport_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .wb_wr_reg              (wb_wr_reg),
    .wb_wr_regindex         (wb_wr_regindex),
    .wb_wr_wdata            (wb_wr_wdata),
    .ll_valid               (ll_valid),
    .ll_regindex            (ll_regindex),
    .ll_wdata               (ll_wdata),
    .ll_ready               (ll_ready),
    .wb2regfile_wr_reg      (wb2regfile_wr_reg),
    .wb2regfile_wr_regindex (wb2regfile_wr_regindex),
    .wb2regfile_wr_wdata    (wb2regfile_wr_wdata),
    .wb_stall_req           (wb_stall_req),
    .dec_rs1_index          (dec_rs1_index),
    .dec_rs2_index          (dec_rs2_index),
    .dec_rs1_busy           (dec_rs1_busy),
    .dec_rs2_busy           (dec_rs2_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO as a queue of pending results.
  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        vld;
  } ent_t;

  ent_t        q[$];
  int          starve = 0;
  logic        m_wr = 1'b0;
  logic [4:0]  m_idx = 5'd0;
  logic [31:0] m_data = 32'd0;
  logic        m_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_busy(input logic [4:0] ix);
    if (ix == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].vld && q[i].idx == ix) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input logic wr, input logic [4:0] wi, input logic [31:0] wd,
                            input logic lv, input logic [4:0] li, input logic [31:0] ld,
                            input logic r);
    int   n;
    int   st_old;
    logic eff, popped, headv;
    ent_t e;
    if (r) begin
      q.delete();
      starve  = 0;
      m_wr    = 1'b0;
      m_idx   = 5'd0;
      m_data  = 32'd0;
      m_stall = 1'b0;
      return;
    end
    n      = q.size();
    st_old = starve;
    eff    = wr && (wi != 5'd0);
    popped = 1'b0;
    headv  = (n > 0) && q[0].vld;
    if (eff) begin
      m_wr = 1'b1; m_idx = wi; m_data = wd;
      foreach (q[i]) if (q[i].vld && q[i].idx == wi) q[i].vld = 1'b0;
    end else if (n > 0) begin
      e = q.pop_front();
      popped = 1'b1;
      m_wr = e.vld;
      if (e.vld) begin m_idx = e.idx; m_data = e.data; end
    end else begin
      m_wr = 1'b0;
    end
    if (lv && (n < DEPTH) && (li != 5'd0)) begin
      e.idx = li; e.data = ld; e.vld = 1'b1;
      q.push_back(e);
    end
    if (n == 0 || popped) starve = 0;
    else if (headv && eff && starve < STARVE_MAX) starve++;
    m_stall = (st_old == STARVE_MAX) && !popped;
  endtask

  // One clock cycle: apply inputs, check decode lookup, advance model,
  // then check the registered outputs just after the edge.
  task automatic cyc(input logic wr, input logic [4:0] wi, input logic [31:0] wd,
                     input logic lv, input logic [4:0] li, input logic [31:0] ld,
                     input logic r);
    rst = r;
    wb_wr_reg = wr; wb_wr_regindex = wi; wb_wr_wdata = wd;
    ll_valid = lv; ll_regindex = li; ll_wdata = ld;
    #1;
    if (!r) begin
      chk("rs1_busy", {31'd0, dec_rs1_busy}, {31'd0, m_busy(dec_rs1_index)});
      chk("rs2_busy", {31'd0, dec_rs2_busy}, {31'd0, m_busy(dec_rs2_index)});
      chk("ll_ready_pre", {31'd0, ll_ready}, {31'd0, (q.size() < DEPTH)});
    end
    model_step(wr, wi, wd, lv, li, ld, r);
    @(posedge clk);
    #1;
    chk("port_wr", {31'd0, wb2regfile_wr_reg}, {31'd0, m_wr});
    if (m_wr) begin
      chk("port_idx", {27'd0, wb2regfile_wr_regindex}, {27'd0, m_idx});
      chk("port_data", wb2regfile_wr_wdata, m_data);
    end
    chk("stall", {31'd0, wb_stall_req}, {31'd0, m_stall});
    chk("ll_ready", {31'd0, ll_ready}, {31'd0, (q.size() < DEPTH)});
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  initial begin
    int wbrate;
    logic wr, lv;
    rst = 1'b1; wb_wr_reg = 1'b0; wb_wr_regindex = 5'd0; wb_wr_wdata = 32'd0;
    ll_valid = 1'b0; ll_regindex = 5'd0; ll_wdata = 32'd0;
    dec_rs1_index = 5'd0; dec_rs2_index = 5'd0;
    @(negedge clk);

    // Reset and idle
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("rst_wr", {31'd0, wb2regfile_wr_reg}, 32'd0);
    chk("rst_idx", {27'd0, wb2regfile_wr_regindex}, 32'd0);
    chk("rst_data", wb2regfile_wr_wdata, 32'd0);
    chk("rst_stall", {31'd0, wb_stall_req}, 32'd0);
    chk("rst_ready", {31'd0, ll_ready}, 32'd1);

    // Pipeline write, one cycle latency
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("wb_lat_wr", {31'd0, wb2regfile_wr_reg}, 32'd1);
    chk("wb_lat_idx", {27'd0, wb2regfile_wr_regindex}, 32'd5);
    chk("wb_lat_data", wb2regfile_wr_wdata, 32'hDEADBEEF);
    idle();

    // Long-latency x7 = 0x11
    dec_rs1_index = 5'd7;
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11, 1'b0);
    chk("ll_busy_c1", {31'd0, dec_rs1_busy}, 32'd1);
    chk("ll_nowr_c1", {31'd0, wb2regfile_wr_reg}, 32'd0);
    idle();
    chk("ll_wr_c2", {31'd0, wb2regfile_wr_reg}, 32'd1);
    chk("ll_idx_c2", {27'd0, wb2regfile_wr_regindex}, 32'd7);
    chk("ll_data_c2", wb2regfile_wr_wdata, 32'h11);
    idle();
    chk("ll_busy_c3", {31'd0, dec_rs1_busy}, 32'd0);

    // Fill to DEPTH behind a busy pipeline, then drain in order
    cyc(1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h33, 1'b0);
    cyc(1'b1, 5'd11, 32'hA1, 1'b1, 5'd4, 32'h44, 1'b0);
    chk("full_ready", {31'd0, ll_ready}, 32'd0);
    cyc(1'b1, 5'd12, 32'hA2, 1'b0, 5'd0, 32'd0, 1'b0);
    idle();
    chk("drain1_idx", {27'd0, wb2regfile_wr_regindex}, 32'd3);
    chk("drain1_ready", {31'd0, ll_ready}, 32'd1);
    idle();
    chk("drain2_idx", {27'd0, wb2regfile_wr_regindex}, 32'd4);
    chk("drain2_data", wb2regfile_wr_wdata, 32'h44);

    // Starvation of x9
    cyc(1'b1, 5'd20, 32'hB0, 1'b1, 5'd9, 32'h99, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, 5'(20 + k), 32'hB0 + 32'(k), 1'b0, 5'd0, 32'd0, 1'b0);
      if (k == 4) chk("starve_nostall", {31'd0, wb_stall_req}, 32'd0);
    end
    chk("starve_stall", {31'd0, wb_stall_req}, 32'd1);
    idle();
    chk("starve_wr_idx", {27'd0, wb2regfile_wr_regindex}, 32'd9);
    chk("starve_wr_data", wb2regfile_wr_wdata, 32'h99);
    chk("starve_clear", {31'd0, wb_stall_req}, 32'd0);

    // WAW squash of x6
    dec_rs1_index = 5'd6;
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hAA, 1'b0);
    cyc(1'b1, 5'd6, 32'hBB, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("waw_data", wb2regfile_wr_wdata, 32'hBB);
    chk("waw_busy", {31'd0, dec_rs1_busy}, 32'd0);
    idle();
    chk("waw_silent", {31'd0, wb2regfile_wr_reg}, 32'd0);
    idle();

    // Long-latency write to x0 is dropped
    dec_rs1_index = 5'd0;
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 1'b0);
    idle();
    chk("x0_nowr", {31'd0, wb2regfile_wr_reg}, 32'd0);

    // Reset with a full FIFO drops everything
    cyc(1'b1, 5'd1, 32'hC1, 1'b1, 5'd13, 32'hD1, 1'b0);
    cyc(1'b1, 5'd2, 32'hC2, 1'b1, 5'd14, 32'hD2, 1'b0);
    chk("prerst_full", {31'd0, ll_ready}, 32'd0);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("midrst_ready", {31'd0, ll_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("midrst_nowr", {31'd0, wb2regfile_wr_reg}, 32'd0);
    end

    // Randomized traffic
    wbrate = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) begin
        case ($urandom_range(2))
          0: wbrate = 20;
          1: wbrate = 60;
          default: wbrate = 95;
        endcase
      end
      dec_rs1_index = 5'($urandom_range(7));
      dec_rs2_index = 5'($urandom_range(31));
      wr = !m_stall && ($urandom_range(99) < wbrate);
      lv = ($urandom_range(99) < 40);
      cyc(wr, 5'($urandom_range(7)), $urandom, lv, 5'($urandom_range(7)), $urandom,
          ($urandom_range(299) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
